ipv4_rx: RTL and testbench

Parametrised IPv4 receive decoder. It sits between the Ethernet MAC payload stream and the transport layer (UDP/ICMP). It consumes a frame's IP packet in DW-bit beats and fully validates the header: version, IHL, header checksum, total length and, optionally, destination address. It skips IP options, strips Ethernet padding beyond total_len, and forwards only the payload, with a last-beat marker and a sticky error code.

---
 rtl/ipv4_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_ipv4_rx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_rx.sv
// ipv4_rx: IPv4 receive decoder. Accepts a packet in DW-bit beats (DW = 4 or 8,
// high nibble first within a byte), validates version, IHL, total length and the
// header checksum, skips options, strips trailing padding and forwards only the
// payload with a last-beat marker and a sticky error code.
// Optional destination-address filter: define IPV4_RX_DA_FILTER_EN.

module ipv4_rx #(
  parameter int          DW       = 4,
  parameter logic [31:0] LOCAL_IP = 32'hC0A8_0164
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid,
  input  logic [DW-1:0] din,
  output logic          dout_valid,
  output logic [DW-1:0] dout,
  output logic          dout_last,
  output logic          hdr_done,
  output logic [7:0]    protocol,
  output logic [31:0]   src_ip,
  output logic [15:0]   payload_len,
  output logic          err,
  output logic [2:0]    err_code
);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    HDR,
    PAYLOAD,
    DRAIN,
    ERR
  } state_t;

  localparam logic [2:0] E_VERSION = 3'd1;
  localparam logic [2:0] E_LENGTH  = 3'd2;
  localparam logic [2:0] E_CSUM    = 3'd3;
  localparam logic [2:0] E_DA      = 3'd4;
  localparam logic [2:0] E_TRUNC   = 3'd5;

  state_t      state;
  logic [15:0] byte_cnt;
  logic        nib_phase;
  logic [3:0]  nib_hi;
  logic [7:0]  word_hi;
  logic [15:0] csum;
  logic [3:0]  ihl;
  logic [15:0] total_len;
  logic [7:0]  proto_sh;
  logic [31:0] src_sh;

  logic        byte_done;
  logic [7:0]  cur_byte;
  logic [15:0] word;
  logic [16:0] sum17;
  logic [15:0] csum_nxt;
  logic [15:0] hdr_len;
  logic        hdr_last;
  logic        pay_last;
  logic [15:0] byte_inc;
  logic        advance;
  logic        da_ok;

  // Byte assembly, checksum fold and frame-position decode for the current beat
  always_comb begin
    byte_done = (DW == 8) ? 1'b1 : nib_phase;
    cur_byte  = (DW == 8) ? 8'(din) : {nib_hi, din[3:0]};
    word      = {word_hi, cur_byte};
    sum17     = {1'b0, csum} + {1'b0, word};
    csum_nxt  = sum17[15:0] + {15'd0, sum17[16]};
    hdr_len   = {10'd0, ihl, 2'b00};
    hdr_last  = byte_done && (byte_cnt == hdr_len - 16'd1);
    pay_last  = byte_done && (byte_cnt == total_len - 16'd1);
    byte_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    advance   = valid && (state == IDLE || state == HDR || state == PAYLOAD);
  end

`ifdef IPV4_RX_DA_FILTER_EN
  logic [31:0] da_sh;
  logic [31:0] da_full;

  // Destination address as seen on this beat, including the final DA byte in flight
  always_comb begin
    da_full = (byte_cnt == 16'd19) ? {da_sh[23:0], cur_byte} : da_sh;
    da_ok   = (da_full == LOCAL_IP) || (da_full == 32'hFFFF_FFFF);
  end

  // Collect header bytes 16..19 into the destination address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_sh <= '0;
    end else if (advance && byte_done && byte_cnt >= 16'd16 && byte_cnt <= 16'd19) begin
      da_sh <= {da_sh[23:0], cur_byte};
    end
  end
`else
  assign da_ok = 1'b1;
`endif

  // Frame byte counter, nibble pairing and running checksum; idle outside a live frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      nib_phase <= 1'b0;
      nib_hi    <= '0;
      word_hi   <= '0;
      csum      <= '0;
    end else if (advance) begin
      if (!byte_done) begin
        nib_hi    <= din[3:0];
        nib_phase <= 1'b1;
      end else begin
        nib_phase <= 1'b0;
        byte_cnt  <= byte_inc;
        if (!byte_cnt[0]) begin
          word_hi <= cur_byte;
        end else begin
          csum <= csum_nxt;
        end
      end
    end else begin
      byte_cnt  <= '0;
      nib_phase <= 1'b0;
      csum      <= '0;
    end
  end

  // Frame state machine: header validation, payload forwarding and error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_IDLE;
      dout_valid  <= 1'b0;
      dout        <= '0;
      dout_last   <= 1'b0;
      hdr_done    <= 1'b0;
      protocol    <= '0;
      src_ip      <= '0;
      payload_len <= '0;
      err         <= 1'b0;
      err_code    <= '0;
      ihl         <= '0;
      total_len   <= '0;
      proto_sh    <= '0;
      src_sh      <= '0;
    end else begin
      hdr_done   <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (!valid) state <= IDLE;
        end
        IDLE, HDR: begin
          if (!valid) begin
            if (state == HDR) begin
              err      <= 1'b1;
              err_code <= E_TRUNC;
              state    <= IDLE;
            end
          end else begin
            if (state == IDLE) begin
              err         <= 1'b0;
              err_code    <= '0;
              protocol    <= '0;
              src_ip      <= '0;
              payload_len <= '0;
              state       <= HDR;
            end
            if (byte_done) begin
              if (byte_cnt == 16'd0) begin
                ihl <= cur_byte[3:0];
                if (cur_byte[7:4] != 4'd4) begin
                  err      <= 1'b1;
                  err_code <= E_VERSION;
                  state    <= ERR;
                end else if (cur_byte[3:0] < 4'd5) begin
                  err      <= 1'b1;
                  err_code <= E_LENGTH;
                  state    <= ERR;
                end
              end else if (byte_cnt == 16'd3) begin
                total_len <= word;
                if (word < hdr_len) begin
                  err      <= 1'b1;
                  err_code <= E_LENGTH;
                  state    <= ERR;
                end
              end else if (byte_cnt == 16'd9) begin
                proto_sh <= cur_byte;
              end else if (byte_cnt >= 16'd12 && byte_cnt <= 16'd15) begin
                src_sh <= {src_sh[23:0], cur_byte};
              end
              if (hdr_last) begin
                if (csum_nxt != 16'hFFFF) begin
                  err      <= 1'b1;
                  err_code <= E_CSUM;
                  state    <= ERR;
                end else if (!da_ok) begin
                  err      <= 1'b1;
                  err_code <= E_DA;
                  state    <= ERR;
                end else begin
                  hdr_done    <= 1'b1;
                  protocol    <= proto_sh;
                  src_ip      <= src_sh;
                  payload_len <= total_len - hdr_len;
                  state       <= (total_len == hdr_len) ? DRAIN : PAYLOAD;
                end
              end
            end
          end
        end
        PAYLOAD: begin
          if (!valid) begin
            err      <= 1'b1;
            err_code <= E_TRUNC;
            state    <= IDLE;
          end else begin
            dout_valid <= 1'b1;
            dout       <= din;
            if (pay_last) begin
              dout_last <= 1'b1;
              state     <= DRAIN;
            end
          end
        end
        DRAIN, ERR: begin
          if (!valid) state <= IDLE;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_rx.sv
// tb_ipv4_rx: directed bench for ipv4_rx with a byte-wide and a nibble-wide
// instance side by side; expected values are hand-computed header constants.

module tb_ipv4_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid8 = 1'b0;
  logic        valid4 = 1'b0;
  logic [7:0]  din8 = '0;
  logic [3:0]  din4 = '0;

  logic        dv8, dl8, hd8, er8;
  logic [7:0]  do8, pr8;
  logic [31:0] si8;
  logic [15:0] pl8;
  logic [2:0]  ec8;

  logic        dv4, dl4, hd4, er4;
  logic [3:0]  do4;
  logic [7:0]  pr4;
  logic [31:0] si4;
  logic [15:0] pl4;
  logic [2:0]  ec4;

  ipv4_rx #(.DW(8)) u8 (
    .clk(clk), .rst_n(rst_n), .valid(valid8), .din(din8),
    .dout_valid(dv8), .dout(do8), .dout_last(dl8), .hdr_done(hd8),
    .protocol(pr8), .src_ip(si8), .payload_len(pl8), .err(er8), .err_code(ec8)
  );

  ipv4_rx #(.DW(4)) u4 (
    .clk(clk), .rst_n(rst_n), .valid(valid4), .din(din4),
    .dout_valid(dv4), .dout(do4), .dout_last(dl4), .hdr_done(hd4),
    .protocol(pr4), .src_ip(si4), .payload_len(pl4), .err(er4), .err_code(ec4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] pkt [0:63];

  logic [7:0] b8 [0:511];
  logic       l8 [0:511];
  int         c8 [0:511];
  int n8 = 0, hdn8 = 0, lc8 = 0, hdcyc8 = 0;

  logic [3:0] b4 [0:511];
  logic       l4 [0:511];
  int         c4 [0:511];
  int n4 = 0, hdn4 = 0, lc4 = 0, hdcyc4 = 0;

  int snap_n = 0, snap_h = 0;

  // Cycle count used to measure hdr_done to first-beat spacing
  always @(posedge clk) cyc++;

  // Record every output beat and pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (dv8 && n8 < 512) begin
        b8[n8] = do8; l8[n8] = dl8; c8[n8] = cyc; n8++;
      end
      if (hd8) begin hdn8++; hdcyc8 = cyc; end
      if (dl8) lc8++;
      if (dv4 && n4 < 512) begin
        b4[n4] = do4; l4[n4] = dl4; c4[n4] = cyc; n4++;
      end
      if (hd4) begin hdn4++; hdcyc4 = cyc; end
      if (dl4) lc4++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic loadFrame(input logic [159:0] h);
    for (int i = 0; i < 20; i++) pkt[i] = h[159-8*i -: 8];
    for (int i = 0; i < 8; i++) pkt[20+i] = 8'(i + 1);
    for (int i = 28; i < 64; i++) pkt[i] = 8'hEE;
  endtask

  task automatic applyStimulus(input bit nib, input int nbytes, input int rst_at, input int gap);
    for (int i = 0; i < nbytes; i++) begin
      if (nib) begin
        @(negedge clk); valid4 = 1'b1; din4 = pkt[i][7:4];
        @(negedge clk); din4 = pkt[i][3:0];
      end else begin
        @(negedge clk); valid8 = 1'b1; din8 = pkt[i];
      end
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        snap_n = n8;
        snap_h = hdn8;
        checkOutput("rst_dout_valid", dv8, 0);
        checkOutput("rst_dout", do8, 0);
        checkOutput("rst_dout_last", dl8, 0);
        checkOutput("rst_hdr_done", hd8, 0);
        checkOutput("rst_protocol", pr8, 0);
        checkOutput("rst_src_ip", si8, 0);
        checkOutput("rst_payload_len", pl8, 0);
        checkOutput("rst_err", {29'd0, ec8} | {31'd0, er8}, 0);
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk); valid8 = 1'b0; valid4 = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic expectGood8(input string tag, input int sn, input int sh, input int sl);
    $display("[TB] checking %s", tag);
    checkOutput("hdr_done_count8", hdn8 - sh, 1);
    checkOutput("beats8", n8 - sn, 8);
    for (int i = 0; i < 8; i++) checkOutput("payload8", b8[sn+i], i + 1);
    checkOutput("last_flag8", l8[sn+7], 1);
    checkOutput("last_count8", lc8 - sl, 1);
    checkOutput("hdr_to_data8", c8[sn] - hdcyc8, 1);
    checkOutput("protocol8", pr8, 8'h11);
    checkOutput("src_ip8", si8, 32'hC0A8_0101);
    checkOutput("payload_len8", pl8, 16'd8);
    checkOutput("err8", er8, 0);
    checkOutput("err_code8", ec8, 0);
  endtask

  task automatic expectErr8(input string tag, input int sn, input int sh, input int code);
    $display("[TB] checking %s", tag);
    checkOutput("err_flag8", er8, 1);
    checkOutput("err_code8", ec8, code);
    checkOutput("err_beats8", n8 - sn, 0);
    checkOutput("err_hdr_done8", hdn8 - sh, 0);
  endtask

  initial begin
    int sn, sh, sl;
    logic [159:0] good;
    logic [159:0] opt;
    good = 160'h4500001C_00004000_4011B71B_C0A80101_C0A80164;
    opt  = 160'h46000020_00004000_4011B415_C0A80101_C0A80164;

    #1;
    $display("[TB] reset state");
    checkOutput("reset_dout_valid", dv8, 0);
    checkOutput("reset_hdr_done", hd8, 0);
    checkOutput("reset_src_ip", si8, 0);
    checkOutput("reset_err_code", ec8, 0);
    checkOutput("reset_dout4", {28'd0, do4} | {31'd0, dv4}, 0);
    #13 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame, byte path
    loadFrame(good);
    sn = n8; sh = hdn8; sl = lc8;
    applyStimulus(1'b0, 46, -1, 3);
    expectGood8("good_dw8", sn, sh, sl);

    // Good frame, nibble path
    sn = n4; sh = hdn4; sl = lc4;
    applyStimulus(1'b1, 46, -1, 3);
    $display("[TB] checking good_dw4");
    checkOutput("hdr_done_count4", hdn4 - sh, 1);
    checkOutput("beats4", n4 - sn, 16);
    for (int i = 0; i < 16; i++)
      checkOutput("payload4", b4[sn+i], (i % 2 == 0) ? 0 : (i / 2) + 1);
    checkOutput("last_flag4", l4[sn+15], 1);
    checkOutput("last_count4", lc4 - sl, 1);
    checkOutput("hdr_to_data4", c4[sn] - hdcyc4, 1);
    checkOutput("protocol4", pr4, 8'h11);
    checkOutput("src_ip4", si4, 32'hC0A8_0101);
    checkOutput("payload_len4", pl4, 16'd8);
    checkOutput("err4", er4, 0);

    // Bad checksum, then a good frame after a single idle cycle
    loadFrame(good);
    pkt[11] = 8'h1C;
    sn = n8; sh = hdn8;
    applyStimulus(1'b0, 46, -1, 1);
    expectErr8("bad_checksum", sn, sh, 3);
    loadFrame(good);
    sn = n8; sh = hdn8; sl = lc8;
    applyStimulus(1'b0, 46, -1, 3);
    expectGood8("after_bad_checksum", sn, sh, sl);

    // IHL=6 with four option bytes
    loadFrame(opt);
    for (int i = 20; i < 24; i++) pkt[i] = 8'h01;
    for (int i = 0; i < 8; i++) pkt[24+i] = 8'(i + 1);
    for (int i = 32; i < 64; i++) pkt[i] = 8'hEE;
    sn = n8; sh = hdn8; sl = lc8;
    applyStimulus(1'b0, 46, -1, 3);
    expectGood8("options_ihl6", sn, sh, sl);

    // Version 6: error one cycle after byte 0, held fields cleared
    loadFrame(good);
    pkt[0] = 8'h65;
    sn = n8; sh = hdn8;
    applyStimulus(1'b0, 1, -1, 1);
    expectErr8("version6", sn, sh, 1);
    checkOutput("version6_protocol_cleared", pr8, 0);
    repeat (2) @(negedge clk);

    // IHL below 5
    loadFrame(good);
    pkt[0] = 8'h44;
    sn = n8; sh = hdn8;
    applyStimulus(1'b0, 46, -1, 3);
    expectErr8("ihl4", sn, sh, 2);

    // total_len shorter than the header
    loadFrame(good);
    pkt[3] = 8'h10;
    sn = n8; sh = hdn8;
    applyStimulus(1'b0, 46, -1, 3);
    expectErr8("total_len_short", sn, sh, 2);

    // Header-only packet: accepted with zero payload
    loadFrame(good);
    pkt[3] = 8'h14; pkt[11] = 8'h23;
    sn = n8; sh = hdn8; sl = lc8;
    applyStimulus(1'b0, 46, -1, 3);
    checkOutput("zero_hdr_done", hdn8 - sh, 1);
    checkOutput("zero_beats", n8 - sn, 0);
    checkOutput("zero_last", lc8 - sl, 0);
    checkOutput("zero_payload_len", pl8, 0);
    checkOutput("zero_err", er8, 0);

    // Truncated after third payload byte
    loadFrame(good);
    sn = n8; sh = hdn8; sl = lc8;
    applyStimulus(1'b0, 23, -1, 3);
    checkOutput("trunc_err", er8, 1);
    checkOutput("trunc_code", ec8, 5);
    checkOutput("trunc_beats", n8 - sn, 3);
    checkOutput("trunc_last", lc8 - sl, 0);
    checkOutput("trunc_hdr_done", hdn8 - sh, 1);

    // Foreign destination address
    loadFrame(160'h4500001C_00004000_4011B71A_C0A80101_C0A80165);
    sn = n8; sh = hdn8; sl = lc8;
    applyStimulus(1'b0, 46, -1, 3);
`ifdef IPV4_RX_DA_FILTER_EN
    expectErr8("da_foreign", sn, sh, 4);
`else
    expectGood8("da_foreign_unfiltered", sn, sh, sl);
`endif

    // Broadcast destination address always passes
    loadFrame(160'h4500001C_00004000_40117928_C0A80101_FFFFFFFF);
    sn = n8; sh = hdn8; sl = lc8;
    applyStimulus(1'b0, 46, -1, 3);
    expectGood8("da_broadcast", sn, sh, sl);

    // Reset pulse mid-payload: rest of frame ignored, next frame passes
    loadFrame(good);
    applyStimulus(1'b0, 46, 24, 3);
    checkOutput("post_reset_beats", n8 - snap_n, 0);
    checkOutput("post_reset_hdr_done", hdn8 - snap_h, 0);
    checkOutput("post_reset_err", er8, 0);
    sn = n8; sh = hdn8; sl = lc8;
    applyStimulus(1'b0, 46, -1, 3);
    expectGood8("after_reset", sn, sh, sl);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
